// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed common-anode seven-segment driver
// Shadowed digit codes, per-digit blank/blink, dead time between slots, registered pins.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BLINK_ROUNDS = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   codes,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     blink,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RND_W = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_ROUNDS - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [RND_W-1:0]          round_q, round_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0]   shadow_codes_q, shadow_codes_d;
  logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_n_q, dp_n_d;

  logic [3:0] cur_code;
  logic       visible;

  // Active-low segment patterns, abcdefg.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b1111110;
      4'hB: g = 7'b0011000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1101010;
      4'hE: g = 7'b1000010;
      4'hF: g = 7'b1000001;
    endcase
    return g;
  endfunction

  always_comb begin
    cnt_d          = cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    round_d        = round_q;
    blink_phase_d  = blink_phase_q;
    shadow_codes_d = shadow_codes_q;
    shadow_dp_d    = shadow_dp_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (round_q == RND_LAST) begin
          round_d       = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (load) begin
      shadow_codes_d = codes;
      shadow_dp_d    = dp_in;
    end

    // Outputs follow the current counters and shadow, so the pins lag by one cycle.
    cur_code = shadow_codes_q[{idx_q, 2'b00} +: 4];
    visible  = (cnt_q >= CNT_DEAD) && !blank[idx_q] && !(blink[idx_q] && blink_phase_q);

    an_d   = '1;
    seg_d  = 7'b1111111;
    dp_n_d = 1'b1;
    if (visible) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
      seg_d  = glyph(cur_code);
      dp_n_d = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      round_q        <= '0;
      blink_phase_q  <= 1'b0;
      shadow_codes_q <= '0;
      shadow_dp_q    <= '0;
      an_q           <= '1;
      seg_q          <= 7'b1111111;
      dp_n_q         <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      round_q        <= round_d;
      blink_phase_q  <= blink_phase_d;
      shadow_codes_q <= shadow_codes_d;
      shadow_dp_q    <= shadow_dp_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_n_q         <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
// Reference model derives slot/digit/phase from the cycle count since reset.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   codes;
  logic [3:0]    dp_in, blank, blink;
  logic          load;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_n;
  logic [3:0] m_code [ND];
  logic       m_dp   [ND];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp_n;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_ROUNDS(BR)
  ) dut (
    .clk(clk), .rst(rst), .codes(codes), .dp_in(dp_in), .blank(blank),
    .blink(blink), .load(load), .seg(seg), .dp_n(dp_n), .an(an)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111110, 7'b0011000,
            7'b0110001, 7'b1101010, 7'b1000010, 7'b1000001};
    return tbl[c];
  endfunction

  // One clock edge: predict the pins produced by this edge, then advance the model.
  task automatic step();
    int cnt, slot, idx, ph;
    bit vis, r, ld;
    logic [15:0] c;
    logic [3:0] d;
    r = rst; ld = load; c = codes; d = dp_in;
    exp_an = 4'hF; exp_seg = 7'b1111111; exp_dp_n = 1'b1;
    if (!r) begin
      cnt  = m_n % SD;
      slot = m_n / SD;
      idx  = slot % ND;
      ph   = (slot / (ND * BR)) % 2;
      vis  = (cnt >= DC) && !blank[idx] && !(blink[idx] && ph == 1);
      if (vis) begin
        exp_an   = ~(4'b0001 << idx);
        exp_seg  = ref_glyph(m_code[idx]);
        exp_dp_n = ~m_dp[idx];
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_n = 0;
      for (int i = 0; i < ND; i++) begin m_code[i] = 4'h0; m_dp[i] = 1'b0; end
    end else begin
      m_n++;
      if (ld) for (int i = 0; i < ND; i++) begin m_code[i] = c[4*i +: 4]; m_dp[i] = d[i]; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; codes = 16'h0; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {4'hF, 7'b1111111, 1'b1}) begin
        n_fail++; $display("FAIL reset_dark: got an=%b seg=%b dp_n=%b want 1111 1111111 1", an, seg, dp_n);
      end
    end
    rst = 1'b0; load = 1'b1; codes = 16'h3210;
    step();
    load = 1'b0;
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_edge1: got an=%b want 1111", an); end
    for (int k = 2; k <= 20; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL reset_scan e%0d: got %b %b %b want %b %b %b", k, an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
      if (k == 2 || k == 18) begin
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b0000001}) begin
          n_fail++; $display("FAIL digit0_e%0d: got an=%b seg=%b want 1110 0000001", k, an, seg);
        end
      end
      if (k == 6) begin
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b1001111}) begin
          n_fail++; $display("FAIL digit1_e6: got an=%b seg=%b want 1101 1001111", an, seg);
        end
      end
      if (k == 17) begin
        n_checks++;
        if (an !== 4'hF) begin n_fail++; $display("FAIL wrap_dead_e17: got an=%b want 1111", an); end
      end
    end
  endtask

  task automatic test_decode();
    codes = 16'hFEDC; dp_in = 4'b0101; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL decode_model: got %b %b %b want %b %b %b", an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
      case (an)
        4'b1110: begin n_checks++; if ({seg, dp_n} !== {7'b0110001, 1'b0}) begin n_fail++; $display("FAIL decode_C: got %b %b want 0110001 0", seg, dp_n); end end
        4'b1101: begin n_checks++; if ({seg, dp_n} !== {7'b1101010, 1'b1}) begin n_fail++; $display("FAIL decode_D: got %b %b want 1101010 1", seg, dp_n); end end
        4'b1011: begin n_checks++; if ({seg, dp_n} !== {7'b1000010, 1'b0}) begin n_fail++; $display("FAIL decode_E: got %b %b want 1000010 0", seg, dp_n); end end
        4'b0111: begin n_checks++; if ({seg, dp_n} !== {7'b1000001, 1'b1}) begin n_fail++; $display("FAIL decode_F: got %b %b want 1000001 1", seg, dp_n); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_blink();
    do_reset();
    codes = 16'h1111; dp_in = 4'h0; blink = 4'b0001; blank = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 2; k <= 70; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL blink_model e%0d: got %b %b %b want %b %b %b", k, an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
      if (k >= 33 && k <= 64) begin
        n_checks++;
        if (an[0] !== 1'b1) begin n_fail++; $display("FAIL blink_dark e%0d: got an=%b want an[0]=1", k, an); end
      end
      if ((k >= 2 && k <= 4) || (k >= 66 && k <= 68)) begin
        n_checks++;
        if (an !== 4'b1110) begin n_fail++; $display("FAIL blink_lit e%0d: got an=%b want 1110", k, an); end
      end
    end
    blink = 4'h0;
  endtask

  task automatic test_blank();
    codes = 16'h8888; blank = 4'b1010; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL blank_model: got %b %b %b want %b %b %b", an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
      n_checks++;
      if (an[1] !== 1'b1 || an[3] !== 1'b1 || $countones(~an) > 1) begin
        n_fail++; $display("FAIL blank_anodes: got an=%b want digits 1,3 off and at most one low", an);
      end
      if (an == 4'b1110 || an == 4'b1011) begin
        n_checks++;
        if (seg !== 7'b0000000) begin n_fail++; $display("FAIL blank_seg8: got %b want 0000000", seg); end
      end
    end
    blank = 4'h0;
  endtask

  task automatic test_load();
    codes = 16'h5555;
    for (int k = 0; k < 16; k++) begin
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL noload_hold: got %b %b %b want %b %b %b", an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
    end
    do_reset();
    codes = 16'h0000;
    step();
    codes = 16'h0009; load = 1'b1;
    step();
    load = 1'b0;
    n_checks++;
    if ({an, seg} !== {4'b1110, 7'b0000001}) begin
      n_fail++; $display("FAIL load_edge_old: got an=%b seg=%b want 1110 0000001", an, seg);
    end
    step();
    n_checks++;
    if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
      n_fail++; $display("FAIL load_next: got %b %b %b want %b %b %b", an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
    end
    step();
    n_checks++;
    if ({an, seg} !== {4'b1110, 7'b0000100}) begin
      n_fail++; $display("FAIL load_midslot: got an=%b seg=%b want 1110 0000100", an, seg);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    codes = 16'h3210; dp_in = 4'b1111; blink = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 40; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({an, seg, dp_n} !== {4'hF, 7'b1111111, 1'b1}) begin
      n_fail++; $display("FAIL midreset_dark: got %b %b %b want 1111 1111111 1", an, seg, dp_n);
    end
    step();
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL midreset_dead: got an=%b want 1111", an); end
    step();
    n_checks++;
    if ({an, seg, dp_n} !== {4'b1110, 7'b0000001, 1'b1}) begin
      n_fail++; $display("FAIL midreset_restart: got %b %b %b want 1110 0000001 1", an, seg, dp_n);
    end
    blink = 4'h0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      codes = 16'($urandom);
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      blink = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
      n_checks++;
      if ({an, seg, dp_n} !== {exp_an, exp_seg, exp_dp_n}) begin
        n_fail++; $display("FAIL random_model k%0d: got %b %b %b want %b %b %b", k, an, seg, dp_n, exp_an, exp_seg, exp_dp_n);
      end
      n_checks++;
      if ($countones(~an) > 1) begin n_fail++; $display("FAIL random_onehot: got an=%b want at most one low", an); end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    m_n = 0;
    for (int i = 0; i < ND; i++) begin m_code[i] = 4'h0; m_dp[i] = 1'b0; end
    rst = 1'b1; load = 1'b0; codes = 16'h0; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    test_reset();
    test_decode();
    test_blink();
    test_blank();
    test_load();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
